// File: rtl/vfifo_dpram_pkg.sv
// Shared types and constants for the vfifo dual-port RAM with built-in clear engine.
package vfifo_dpram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam logic RDW_OLD = 1'b0;
    localparam logic RDW_NEW = 1'b1;

    function automatic int be_width(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/vfifo_dpram_clr_fsm.sv
// Clear sequencer: walks every address once after reset or on request, then hands the ports over.
module vfifo_dpram_clr_fsm
    import vfifo_dpram_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req,
    output logic                  ready,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_adr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADR = {ADDR_WIDTH{1'b1}};

    state_e                state_r;
    state_e                state_nx_s;
    logic [ADDR_WIDTH-1:0] cnt_r;
    logic [ADDR_WIDTH-1:0] cnt_nx_s;
    logic                  ready_r;

    // State, clear counter and ready flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_CLEAR;
            cnt_r   <= '0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            ready_r <= (state_nx_s == ST_RUN);
        end
    end

    // Next-state logic; clr_req only counts while the ports are live
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_CLEAR: begin
                if (cnt_r == LAST_ADR) begin
                    state_nx_s = ST_RUN;
                    cnt_nx_s   = '0;
                end else begin
                    cnt_nx_s   = cnt_r + ADDR_WIDTH'(1);
                end
            end
            ST_RUN: begin
                if (clr_req) begin
                    state_nx_s = ST_CLEAR;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            default: begin
                state_nx_s = ST_CLEAR;
                cnt_nx_s   = '0;
            end
        endcase
    end

    assign ready   = ready_r;
    assign clr_we  = (state_r == ST_CLEAR);
    assign clr_adr = cnt_r;

endmodule

// File: rtl/vfifo_dpram_sc_be_clr.sv
// Single-clock true dual-port RAM with byte enables, RDW mode, collision flag and clear engine.
// Optional VFIFO_DPRAM_OUTREG_EN adds one output register stage on q_a/q_b/coll.
module vfifo_dpram_sc_be_clr
    import vfifo_dpram_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    BYTE_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 9,
    parameter bit                    RDW_MODE    = 1'b0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [ADDR_WIDTH-1:0]                        adr_a,
    input  logic [ADDR_WIDTH-1:0]                        adr_b,
    input  logic [DATA_WIDTH-1:0]                        d_a,
    input  logic [DATA_WIDTH-1:0]                        d_b,
    input  logic [be_width(DATA_WIDTH, BYTE_WIDTH)-1:0]  be_a,
    input  logic [be_width(DATA_WIDTH, BYTE_WIDTH)-1:0]  be_b,
    input  logic                                         we_a,
    input  logic                                         we_b,
    input  logic                                         re_a,
    input  logic                                         re_b,
    output logic [DATA_WIDTH-1:0]                        q_a,
    output logic [DATA_WIDTH-1:0]                        q_b,
    input  logic                                         clr_req,
    output logic                                         ready,
    output logic                                         coll
);

    localparam int NB    = be_width(DATA_WIDTH, BYTE_WIDTH);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  ready_s;
    logic                  clr_we_s;
    logic [ADDR_WIDTH-1:0] clr_adr_s;
    logic [ADDR_WIDTH-1:0] wa_adr_s;
    logic [DATA_WIDTH-1:0] wa_dat_s;
    logic [NB-1:0]         wa_be_s;
    logic [NB-1:0]         wb_be_s;
    logic [DATA_WIDTH-1:0] fwd_a_s;
    logic [DATA_WIDTH-1:0] fwd_b_s;
    logic                  coll_s;
    logic [DATA_WIDTH-1:0] q_a_r;
    logic [DATA_WIDTH-1:0] q_b_r;
    logic                  coll_r;

    vfifo_dpram_clr_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clr_fsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .ready   (ready_s),
        .clr_we  (clr_we_s),
        .clr_adr (clr_adr_s)
    );

    // Port A write path is borrowed by the clear engine; port B is silenced meanwhile
    always_comb begin
        wa_adr_s = adr_a;
        wa_dat_s = d_a;
        wa_be_s  = '0;
        wb_be_s  = '0;
        if (clr_we_s) begin
            wa_adr_s = clr_adr_s;
            wa_dat_s = CLEAR_VALUE;
            wa_be_s  = '1;
            wb_be_s  = '0;
        end else begin
            wa_be_s  = we_a ? be_a : '0;
            wb_be_s  = we_b ? be_b : '0;
        end
    end

    // Byte-wise array update; port A is written last so it wins on a shared address
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wb_be_s[i]) begin
                mem[adr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= d_b[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (wa_be_s[i]) begin
                mem[wa_adr_s][i*BYTE_WIDTH +: BYTE_WIDTH] <= wa_dat_s[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Read word with same-port write-first merge when selected; cross-port is always old data
    always_comb begin
        fwd_a_s = mem[adr_a];
        fwd_b_s = mem[adr_b];
        for (int i = 0; i < NB; i++) begin
            fwd_a_s[i*BYTE_WIDTH +: BYTE_WIDTH] = (RDW_MODE == RDW_NEW && we_a && be_a[i]) ?
                d_a[i*BYTE_WIDTH +: BYTE_WIDTH] : fwd_a_s[i*BYTE_WIDTH +: BYTE_WIDTH];
            fwd_b_s[i*BYTE_WIDTH +: BYTE_WIDTH] = (RDW_MODE == RDW_NEW && we_b && be_b[i]) ?
                d_b[i*BYTE_WIDTH +: BYTE_WIDTH] : fwd_b_s[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    assign coll_s = ready_s && (adr_a == adr_b) &&
                    ((we_a && (|be_a) && (we_b || re_b)) ||
                     (we_b && (|be_b) && (we_a || re_a)));

    // Read data and collision registers; q holds when not read or while clearing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_a_r  <= '0;
            q_b_r  <= '0;
            coll_r <= 1'b0;
        end else begin
            coll_r <= coll_s;
            if (ready_s && re_a) begin
                q_a_r <= fwd_a_s;
            end
            if (ready_s && re_b) begin
                q_b_r <= fwd_b_s;
            end
        end
    end

`ifdef VFIFO_DPRAM_OUTREG_EN
    logic [DATA_WIDTH-1:0] q_a_o_r;
    logic [DATA_WIDTH-1:0] q_b_o_r;
    logic                  coll_o_r;

    // Free-running output stage keeps coll aligned with the delayed read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_a_o_r  <= '0;
            q_b_o_r  <= '0;
            coll_o_r <= 1'b0;
        end else begin
            q_a_o_r  <= q_a_r;
            q_b_o_r  <= q_b_r;
            coll_o_r <= coll_r;
        end
    end

    assign q_a  = q_a_o_r;
    assign q_b  = q_b_o_r;
    assign coll = coll_o_r;
`else
    assign q_a  = q_a_r;
    assign q_b  = q_b_r;
    assign coll = coll_r;
`endif

    assign ready = ready_s;

endmodule

// File: tb/tb_vfifo_dpram_sc_be_clr.sv
// Bench: two instances (old-data and write-first RDW) driven identically, checked against a word-level model.
module tb_vfifo_dpram_sc_be_clr;

    localparam logic [31:0] CV = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  adr_a = '0, adr_b = '0;
    logic [31:0] d_a = '0, d_b = '0;
    logic [3:0]  be_a = '0, be_b = '0;
    logic        we_a = 1'b0, we_b = 1'b0, re_a = 1'b0, re_b = 1'b0, clr_req = 1'b0;

    logic [31:0] q_a0, q_b0, q_a1, q_b1;
    logic        ready0, ready1, coll0, coll1;

    int checks = 0;
    int errors = 0;

    // Reference state per instance (index 0 = old data, 1 = write-first)
    logic [31:0] mm [2][16];
    int          clr_left [2];
    bit          rdy [2];
    logic [31:0] qa_m [2], qb_m [2], qa_o [2], qb_o [2];
    logic        cl_m [2], cl_o [2];

    always #5 clk = ~clk;

    vfifo_dpram_sc_be_clr #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4),
                            .RDW_MODE(1'b0), .CLEAR_VALUE(CV)) dut0 (
        .clk(clk), .rst_n(rst_n), .adr_a(adr_a), .adr_b(adr_b), .d_a(d_a), .d_b(d_b),
        .be_a(be_a), .be_b(be_b), .we_a(we_a), .we_b(we_b), .re_a(re_a), .re_b(re_b),
        .q_a(q_a0), .q_b(q_b0), .clr_req(clr_req), .ready(ready0), .coll(coll0));

    vfifo_dpram_sc_be_clr #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4),
                            .RDW_MODE(1'b1), .CLEAR_VALUE(CV)) dut1 (
        .clk(clk), .rst_n(rst_n), .adr_a(adr_a), .adr_b(adr_b), .d_a(d_a), .d_b(d_b),
        .be_a(be_a), .be_b(be_b), .we_a(we_a), .we_b(we_b), .re_a(re_a), .re_b(re_b),
        .q_a(q_a1), .q_b(q_b1), .clr_req(clr_req), .ready(ready1), .coll(coll1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        end
        return r;
    endfunction

    task automatic check_outputs(input string ph);
        logic [31:0] ea [2], eb [2];
        logic        ec [2];
        for (int m = 0; m < 2; m++) begin
`ifdef VFIFO_DPRAM_OUTREG_EN
            ea[m] = qa_o[m]; eb[m] = qb_o[m]; ec[m] = cl_o[m];
`else
            ea[m] = qa_m[m]; eb[m] = qb_m[m]; ec[m] = cl_m[m];
`endif
        end
        chk({ph, " ready0"}, {31'd0, ready0}, {31'd0, rdy[0]});
        chk({ph, " ready1"}, {31'd0, ready1}, {31'd0, rdy[1]});
        chk({ph, " q_a0"}, q_a0, ea[0]);
        chk({ph, " q_b0"}, q_b0, eb[0]);
        chk({ph, " q_a1"}, q_a1, ea[1]);
        chk({ph, " q_b1"}, q_b1, eb[1]);
        chk({ph, " coll0"}, {31'd0, coll0}, {31'd0, ec[0]});
        chk({ph, " coll1"}, {31'd0, coll1}, {31'd0, ec[1]});
    endtask

    // One clock: advance the model with the current inputs, clock, then compare
    task automatic step(input string ph);
        logic [31:0] nqa, nqb;
        logic        ncl;
        for (int m = 0; m < 2; m++) begin
            nqa = qa_m[m];
            nqb = qb_m[m];
            ncl = 1'b0;
            if (rdy[m]) begin
                if (re_a) nqa = (m == 1 && we_a) ? merge(mm[m][adr_a], d_a, be_a) : mm[m][adr_a];
                if (re_b) nqb = (m == 1 && we_b) ? merge(mm[m][adr_b], d_b, be_b) : mm[m][adr_b];
                ncl = (adr_a == adr_b) && ((we_a && be_a != 4'd0 && (we_b || re_b)) ||
                                           (we_b && be_b != 4'd0 && (we_a || re_a)));
                if (we_b) mm[m][adr_b] = merge(mm[m][adr_b], d_b, be_b);
                if (we_a) mm[m][adr_a] = merge(mm[m][adr_a], d_a, be_a);
                if (clr_req) begin
                    rdy[m] = 1'b0;
                    clr_left[m] = 16;
                end
            end else begin
                mm[m][16 - clr_left[m]] = CV;
                clr_left[m]--;
                if (clr_left[m] == 0) rdy[m] = 1'b1;
            end
            qa_o[m] = qa_m[m];
            qb_o[m] = qb_m[m];
            cl_o[m] = cl_m[m];
            qa_m[m] = nqa;
            qb_m[m] = nqb;
            cl_m[m] = ncl;
        end
        @(posedge clk);
        #1;
        check_outputs(ph);
    endtask

    task automatic idle();
        we_a = 1'b0; we_b = 1'b0; re_a = 1'b0; re_b = 1'b0; clr_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            qa_m[m] = '0; qb_m[m] = '0; qa_o[m] = '0; qb_o[m] = '0;
            cl_m[m] = 1'b0; cl_o[m] = 1'b0; rdy[m] = 1'b0; clr_left[m] = 16;
        end
        check_outputs("reset");
        chk("reset ready const", {31'd0, ready0}, 32'd0);
        chk("reset q_a const", q_a0, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        do_reset();

        // Initial clear: ready must appear on the 16th edge
        repeat (15) step("init_clear");
        chk("ready before 16th edge", {31'd0, ready0}, 32'd0);
        step("init_clear_last");
        chk("ready after 16 edges", {31'd0, ready0}, 32'd1);

        for (int a = 0; a < 16; a++) begin
            adr_a = 4'(a); adr_b = 4'(15 - a); re_a = 1'b1; re_b = 1'b1;
            step("scan");
        end
        idle(); step("scan_idle");
        chk("scan last a", q_a0, CV);
        chk("scan last b", q_b1, CV);

        // Byte-enable write over the clear pattern
        we_a = 1'b1; adr_a = 4'd3; d_a = 32'h11223344; be_a = 4'b0101;
        step("be_wr");
        idle(); re_a = 1'b1; step("be_rd");
        idle(); step("be_idle");
        chk("be merge dut0", q_a0, 32'hA522A544);
        chk("be merge dut1", q_a1, 32'hA522A544);

        // Same-port read-during-write on port B
        we_b = 1'b1; adr_b = 4'd5; d_b = 32'h0; be_b = 4'b1111;
        step("rdw_init");
        idle(); we_b = 1'b1; re_b = 1'b1; adr_b = 4'd5; d_b = 32'hFFFFFFFF; be_b = 4'b0011;
        step("rdw");
        idle(); step("rdw_idle");
        chk("rdw old", q_b0, 32'h0);
        chk("rdw new", q_b1, 32'h0000FFFF);

        // Write/write collision at address 7
        we_a = 1'b1; we_b = 1'b1; adr_a = 4'd7; adr_b = 4'd7;
        d_a = 32'h11111111; be_a = 4'b1100; d_b = 32'h22222222; be_b = 4'b1111;
        step("ww");
        idle(); step("ww_idle1");
        step("ww_idle2");
        step("ww_idle3");
        re_a = 1'b1; adr_a = 4'd7; step("ww_rd");
        idle(); step("ww_rd_idle");
        chk("ww merge", q_a0, 32'h11112222);

        // Clear request, then reset 5 cycles into the clear
        clr_req = 1'b1; re_a = 1'b1; adr_a = 4'd7; step("clr_req");
        idle();
        repeat (5) step("clr_part");
        do_reset();
        repeat (16) step("clr_full");
        chk("ready after reclear", {31'd0, ready1}, 32'd1);

        // Back-to-back reads of 0,1,2
        for (int a = 0; a < 3; a++) begin
            re_a = 1'b1; adr_a = 4'(a); step("b2b");
        end
        idle(); step("b2b_idle1"); step("b2b_idle2");

        // Randomized traffic on a narrow address range to provoke conflicts
        for (int n = 0; n < 400; n++) begin
            adr_a = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            adr_b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            d_a = $urandom; d_b = $urandom;
            be_a = 4'($urandom); be_b = 4'($urandom);
            we_a = 1'($urandom); we_b = 1'($urandom);
            re_a = 1'($urandom); re_b = 1'($urandom);
            clr_req = ($urandom_range(0, 59) == 0);
            step("rand");
            if (n == 200) begin
                idle();
                do_reset();
            end
        end
        idle(); step("end1"); step("end2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
